// File: rtl/uart_rx_byte_pkg.sv
// uart_rx_byte_pkg: FSM state encoding and bit-period helper shared by the UART blocks.
`timescale 1ns/1ps
package uart_rx_byte_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_rx_byte_sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit, with selectable reset value.
`timescale 1ns/1ps
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= {RST_VAL, RST_VAL};
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 LSB-first serial receiver with mid-bit sampling, framing-error flag and break hold-off.
`timescale 1ns/1ps
module uart_rx_byte
  import uart_rx_byte_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int N  = clks_per_bit(CLK_HZ, BAUD);
  localparam int CW = $clog2(N);
  if (N < 8) begin : g_bad_rate
    $error("uart_rx_byte: CLK_HZ/BAUD must be at least 8");
  end
  logic          rx_s;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(rxd), .q(rx_s));
  // busy is registered alongside state so it tracks state != IDLE exactly
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bitn      <= '0;
      sh        <= '0;
      rx_data   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE:
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        START:
          if (cnt == CW'(N/2 - 1)) begin
            cnt   <= '0;
            bitn  <= '0;
            state <= rx_s ? IDLE : DATA;
            busy  <= !rx_s;
          end else cnt <= cnt + 1'b1;
        DATA:
          if (cnt == CW'(N - 1)) begin
            cnt  <= '0;
            sh   <= {rx_s, sh[7:1]};
            bitn <= bitn + 1'b1;
            if (bitn == 3'd7) state <= STOP;
          end else cnt <= cnt + 1'b1;
        STOP:
          if (cnt == CW'(N - 1)) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data <= sh;
              valid   <= 1'b1;
              state   <= IDLE;
              busy    <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else cnt <= cnt + 1'b1;
        BRK:
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
endmodule
